osc_ddr_writer: RTL

//  AXI4 write master for the oscilloscope capture path. It sits directly

---
 rtl/osc_ddr_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/osc_ddr_writer.sv
// Single-beat AXI4 write master for the oscilloscope capture path.
// Each start/addr/data request becomes one 64-bit write to DDR; errors and timeouts are tracked.
module osc_ddr_writer #(
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [63:0]       i_data,
  output logic              o_done,
  output logic              o_busy,
  output logic [15:0]       o_err_cnt,
  output logic              o_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [63:0]       m_axi_wdata,
  output logic [7:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 2);
  localparam int unsigned HCNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP, HOLD} state_t;

  state_t              state, state_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic [HCNT_W-1:0]   hcnt, hcnt_d;
  logic [ADDR_W-1:0]   awaddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                awvalid_d, wvalid_d, bready_d, done_d, busy_d, timeout_d;
  logic [ERR_W-1:0]    err_cnt_d;
  logic                err_hit, tcnt_run, launch;

  // Fixed single-beat, full-width INCR burst attributes.
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = m_axi_wvalid;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      hcnt          <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      o_done        <= 1'b0;
      o_busy        <= 1'b0;
      o_err_cnt     <= '0;
      o_timeout     <= 1'b0;
    end else begin
      state         <= state_d;
      tcnt          <= tcnt_d;
      hcnt          <= hcnt_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      o_done        <= done_d;
      o_busy        <= busy_d;
      o_err_cnt     <= err_cnt_d;
      o_timeout     <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    hcnt_d    = hcnt;
    awaddr_d  = m_axi_awaddr;
    wdata_d   = m_axi_wdata;
    awvalid_d = m_axi_awvalid;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    done_d    = 1'b0;
    err_hit   = 1'b0;
    tcnt_run  = 1'b0;
    launch    = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          launch    = 1'b1;
          awaddr_d  = {i_addr[ADDR_W-1:3], 3'b000};
          wdata_d   = i_data;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          err_hit   = (i_addr[2:0] != 3'b000);
          state_d   = XFER;
        end
      end
      XFER: begin
        tcnt_run = 1'b1;
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
        // A channel whose valid is already low has completed its handshake.
        if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_hit  = (m_axi_bresp != 2'b00);
          hcnt_d   = '0;
          state_d  = HOLD;
        end else begin
          tcnt_run = 1'b1;
        end
      end
      HOLD: begin
        if (hcnt == HCNT_W'(HOLDOFF)) state_d = IDLE;
        else                          hcnt_d  = hcnt + HCNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Elapsed-cycle count since launch, saturating; value equals the current cycle index.
    tcnt_d = tcnt;
    if (launch)                     tcnt_d = TCNT_W'(1);
    else if (tcnt_run && tcnt != '1) tcnt_d = tcnt + TCNT_W'(1);

    timeout_d = o_timeout || (tcnt_d > TCNT_W'(TIMEOUT));
    err_cnt_d = (err_hit && o_err_cnt != '1) ? o_err_cnt + ERR_W'(1) : o_err_cnt;
    busy_d    = (state_d != IDLE);
  end

endmodule
